// File: rtl/vga_timing_pkg.sv
// Shared timing constants and pipeline types for the VGA scan engine.
package vga_timing_pkg;

  localparam int unsigned CNT_W        = 10;

  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_TOTAL      = 521;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 751;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 491;
  localparam int unsigned WIN_X0       = 192;
  localparam int unsigned WIN_Y0       = 112;
  localparam int unsigned WIN_LOG2     = 8;
  localparam int unsigned COLOR_W      = 3;

  // Per-pixel flags travelling from stage 1 to stage 2; syncs are active low.
  typedef struct packed {
    logic win;
    logic hs;
    logic vs;
    logic first;
  } stage_flags_t;

  localparam stage_flags_t STAGE_FLAGS_RESET = '{win: 1'b0, hs: 1'b1, vs: 1'b1, first: 1'b0};

endpackage

// File: rtl/vga_scan_reader_if.sv
// Frame-RAM read port plus VGA pin bundle; master is the scan engine side.
interface vga_scan_reader_if #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned COLOR_W = 3
);
  logic [COLOR_W-1:0] iColor;
  logic [ADDR_W-1:0]  oColorAddress;
  logic               oHs;
  logic               oVs;
  logic [COLOR_W-1:0] oRGB;
  logic               oFrameStart;

  modport master (
    input  iColor,
    output oColorAddress, oHs, oVs, oRGB, oFrameStart
  );

  modport slave (
    output iColor,
    input  oColorAddress, oHs, oVs, oRGB, oFrameStart
  );
endinterface

// File: rtl/vga_scan_reader_axis_counter.sv
// Wrap counter with enable and terminal-count flag, used for both scan axes.
module vga_axis_counter #(
  parameter int unsigned MAX = 800,
  parameter int unsigned W   = 10
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(MAX - 1));

  // Advance on enable, wrapping to zero after MAX-1.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)   count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
  end

endmodule

// File: rtl/vga_scan_reader.sv
// VGA scan engine: pixel timing, centred-window RAM addressing and a
// two-tick output pipeline that absorbs the frame RAM's 1-clock read latency.
// Optional macro VGA_TEST_PATTERN_EN replaces RAM colour with 8 colour bars.
module vga_scan_reader
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = vga_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL      = vga_timing_pkg::V_TOTAL,
  parameter int unsigned H_SYNC_START = vga_timing_pkg::H_SYNC_START,
  parameter int unsigned H_SYNC_END   = vga_timing_pkg::H_SYNC_END,
  parameter int unsigned V_SYNC_START = vga_timing_pkg::V_SYNC_START,
  parameter int unsigned V_SYNC_END   = vga_timing_pkg::V_SYNC_END,
  parameter int unsigned WIN_X0       = vga_timing_pkg::WIN_X0,
  parameter int unsigned WIN_Y0       = vga_timing_pkg::WIN_Y0,
  parameter int unsigned WIN_LOG2     = vga_timing_pkg::WIN_LOG2,
  parameter int unsigned COLOR_W      = vga_timing_pkg::COLOR_W
) (
  input  logic               Clock,
  input  logic               Reset,
  vga_scan_reader_if.master  bus
);

  localparam int unsigned ADDR_W = 2 * WIN_LOG2;
  localparam int unsigned WIN_SZ = 2 ** WIN_LOG2;

  localparam logic [CNT_W-1:0] X0  = CNT_W'(WIN_X0);
  localparam logic [CNT_W-1:0] X1  = CNT_W'(WIN_X0 + WIN_SZ - 1);
  localparam logic [CNT_W-1:0] Y0  = CNT_W'(WIN_Y0);
  localparam logic [CNT_W-1:0] Y1  = CNT_W'(WIN_Y0 + WIN_SZ - 1);
  localparam logic [CNT_W-1:0] HS0 = CNT_W'(H_SYNC_START);
  localparam logic [CNT_W-1:0] HS1 = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] VS0 = CNT_W'(V_SYNC_START);
  localparam logic [CNT_W-1:0] VS1 = CNT_W'(V_SYNC_END);

  logic                rTick;
  logic                tick;
  logic [CNT_W-1:0]    hcount;
  logic [CNT_W-1:0]    vcount;
  logic                h_tc;
  logic                v_tc;
  logic                at_origin;

  logic                win0;
  logic                hs_raw;
  logic                vs_raw;
  logic [WIN_LOG2-1:0] hoff;
  logic [WIN_LOG2-1:0] voff;

  logic [ADDR_W-1:0]   addr_q;
  stage_flags_t        s1;
  logic [COLOR_W-1:0]  rgb_q;
  logic                hs_q;
  logic                vs_q;
  logic                fs_q;

  // Pixel tick: every second clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) rTick <= 1'b0;
    else       rTick <= ~rTick;
  end

  assign tick = rTick;

  vga_axis_counter #(.MAX(H_TOTAL), .W(CNT_W)) u_hcnt (
    .Clock (Clock),
    .Reset (Reset),
    .en    (tick),
    .count (hcount),
    .tc    (h_tc)
  );

  vga_axis_counter #(.MAX(V_TOTAL), .W(CNT_W)) u_vcnt (
    .Clock (Clock),
    .Reset (Reset),
    .en    (tick & h_tc),
    .count (vcount),
    .tc    (v_tc)
  );

  // Tracks hcount==0 && vcount==0: set out of reset and whenever both axes wrap together.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)     at_origin <= 1'b1;
    else if (tick) at_origin <= h_tc & v_tc;
  end

  assign win0   = (hcount >= X0) && (hcount <= X1) && (vcount >= Y0) && (vcount <= Y1);
  assign hs_raw = !((hcount >= HS0) && (hcount <= HS1));
  assign vs_raw = !((vcount >= VS0) && (vcount <= VS1));
  assign hoff   = WIN_LOG2'(hcount - X0);
  assign voff   = WIN_LOG2'(vcount - Y0);

`ifdef VGA_TEST_PATTERN_EN
  logic [WIN_LOG2-1:0] hoff1;
  logic [2:0]          bar;

  assign bar = 3'(hoff1 >> (WIN_LOG2 - 3));
`endif

  // Stage 1: issue RAM address and capture per-pixel flags.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_q <= '0;
      s1     <= STAGE_FLAGS_RESET;
`ifdef VGA_TEST_PATTERN_EN
      hoff1  <= '0;
`endif
    end else if (tick) begin
      addr_q <= win0 ? {voff, hoff} : '0;
      s1     <= '{win: win0, hs: hs_raw, vs: vs_raw, first: at_origin};
`ifdef VGA_TEST_PATTERN_EN
      hoff1  <= hoff;
`endif
    end
  end

  // Stage 2: register colour (RAM data has settled) alongside the delayed syncs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      fs_q  <= 1'b0;
    end else if (tick) begin
`ifdef VGA_TEST_PATTERN_EN
      rgb_q <= s1.win ? COLOR_W'(bar) : '0;
`else
      rgb_q <= s1.win ? bus.iColor : '0;
`endif
      hs_q  <= s1.hs;
      vs_q  <= s1.vs;
      fs_q  <= s1.first;
    end else begin
      fs_q  <= 1'b0;
    end
  end

  assign bus.oColorAddress = addr_q;
  assign bus.oRGB          = rgb_q;
  assign bus.oHs           = hs_q;
  assign bus.oVs           = vs_q;
  assign bus.oFrameStart   = fs_q;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench for vga_scan_reader: a scaled-down geometry instance for
// window/frame behaviour plus a default-geometry instance for line timing.
module tb_vga_scan_reader;

  localparam int HT = 40;
  localparam int FRAME_K = 2 * HT * 24;

  logic clk = 1'b0;
  logic Reset;
  logic force7;
  int   cyc;
  int   fs_cnt;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vga_scan_reader_if #(.ADDR_W(8), .COLOR_W(3)) bus ();
  vga_scan_reader_if #(.ADDR_W(16), .COLOR_W(3)) bus_d ();

  vga_scan_reader #(
    .H_TOTAL(40), .V_TOTAL(24),
    .H_SYNC_START(30), .H_SYNC_END(33),
    .V_SYNC_START(21), .V_SYNC_END(22),
    .WIN_X0(8), .WIN_Y0(4), .WIN_LOG2(4), .COLOR_W(3)
  ) dut (
    .Clock (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  vga_scan_reader dut_d (
    .Clock (clk),
    .Reset (Reset),
    .bus   (bus_d)
  );

  // Frame RAM stub: one-clock read latency, data = low 3 address bits (or forced 7).
  always @(posedge clk) bus.iColor <= force7 ? 3'd7 : bus.oColorAddress[2:0];
  assign bus_d.iColor = 3'd0;

  // Clock count since the last reset release (first edge after release is 1).
  always @(posedge clk or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (Reset)                fs_cnt <= 0;
    else if (bus.oFrameStart) fs_cnt <= fs_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after clock edge k; cyc only grows, so the loop is bounded.
  task automatic wait_k(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edge after which scaled-instance data for pixel (h,v) is visible:
  // off=2 for the address, off=4 for sync/colour outputs.
  function automatic int kp(input int h, input int v, input int off, input int frame);
    return 2 * (v * HT + h) + off + frame * FRAME_K;
  endfunction

  function automatic int exp_rgb(input int h, input int v, input int col);
    bit inwin;
    inwin = (h >= 8) && (h <= 23) && (v >= 4) && (v <= 19);
`ifdef VGA_TEST_PATTERN_EN
    return inwin ? (((h - 8) >> 1) & 7) : 0;
`else
    return inwin ? col : 0;
`endif
  endfunction

  initial begin
    Reset  = 1'b1;
    force7 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("rst_hs",   32'(bus.oHs), 1);
    check("rst_vs",   32'(bus.oVs), 1);
    check("rst_rgb",  32'(bus.oRGB), 0);
    check("rst_addr", 32'(bus.oColorAddress), 0);
    check("rst_fs",   32'(bus.oFrameStart), 0);
    check("rst_d_hs", 32'(bus_d.oHs), 1);
    check("rst_d_vs", 32'(bus_d.oVs), 1);
    check("rst_d_addr", 32'(bus_d.oColorAddress), 0);
    @(negedge clk);
    Reset = 1'b0;

    wait_k(1); check("post_rel_hs", 32'(bus.oHs), 1);
    wait_k(4); check("fs_first", 32'(bus.oFrameStart), 1);
    wait_k(5); check("fs_width", 32'(bus.oFrameStart), 0);

    wait_k(kp(29, 0, 4, 0)); check("hs_h29", 32'(bus.oHs), 1);
    wait_k(kp(30, 0, 4, 0)); check("hs_h30", 32'(bus.oHs), 0);
    wait_k(kp(33, 0, 4, 0)); check("hs_h33", 32'(bus.oHs), 0);
    wait_k(kp(34, 0, 4, 0)); check("hs_h34", 32'(bus.oHs), 1);

    wait_k(kp(7, 4, 2, 0));  check("addr_h7v4",  32'(bus.oColorAddress), 0);
    wait_k(kp(9, 4, 2, 0));  check("addr_h9v4",  32'(bus.oColorAddress), 1);
    wait_k(kp(9, 4, 4, 0));  check("rgb_h9v4",   32'(bus.oRGB), 32'(exp_rgb(9, 4, 1)));
    wait_k(kp(14, 4, 4, 0)); check("rgb_h14v4",  32'(bus.oRGB), 32'(exp_rgb(14, 4, 6)));
    wait_k(kp(23, 4, 2, 0)); check("addr_h23v4", 32'(bus.oColorAddress), 15);
    wait_k(kp(24, 4, 2, 0)); check("addr_h24v4", 32'(bus.oColorAddress), 0);
    wait_k(kp(8, 5, 2, 0));  check("addr_h8v5",  32'(bus.oColorAddress), 16);
    wait_k(kp(13, 6, 4, 0)); check("rgb_h13v6",  32'(bus.oRGB), 32'(exp_rgb(13, 6, 5)));
    wait_k(kp(23, 19, 2, 0)); check("addr_last", 32'(bus.oColorAddress), 255);
    wait_k(kp(23, 19, 4, 0)); check("rgb_last",  32'(bus.oRGB), 32'(exp_rgb(23, 19, 7)));

    wait_k(kp(39, 20, 4, 0)); check("vs_v20", 32'(bus.oVs), 1);
    wait_k(kp(0, 21, 4, 0));  check("vs_v21", 32'(bus.oVs), 0);
    wait_k(kp(39, 22, 4, 0)); check("vs_v22", 32'(bus.oVs), 0);
    wait_k(kp(0, 23, 4, 0));  check("vs_v23", 32'(bus.oVs), 1);
    check("fs_count_f1", 32'(fs_cnt), 1);

    force7 = 1'b1;
    wait_k(kp(12, 3, 4, 1));  check("f7_v3",    32'(bus.oRGB), 0);
    wait_k(kp(8, 4, 4, 1));   check("f7_first", 32'(bus.oRGB), 32'(exp_rgb(8, 4, 7)));
    wait_k(kp(7, 10, 4, 1));  check("f7_h7",    32'(bus.oRGB), 0);
    wait_k(kp(12, 10, 4, 1)); check("f7_in",    32'(bus.oRGB), 32'(exp_rgb(12, 10, 7)));
    wait_k(kp(24, 10, 4, 1)); check("f7_h24",   32'(bus.oRGB), 0);
    wait_k(kp(23, 19, 4, 1)); check("f7_last",  32'(bus.oRGB), 32'(exp_rgb(23, 19, 7)));
    wait_k(kp(12, 20, 4, 1)); check("f7_v20",   32'(bus.oRGB), 0);

    // Counter sits at (15,10) after edge 2p+1; address shows (14,10), RGB shows (13,10).
    wait_k(kp(15, 10, 1, 2));
    check("mid_addr_pre", 32'(bus.oColorAddress), 102);
    check("mid_rgb_pre",  32'(bus.oRGB), 32'(exp_rgb(13, 10, 7)));
    Reset = 1'b1;
    #1;
    check("mid_addr", 32'(bus.oColorAddress), 0);
    check("mid_rgb",  32'(bus.oRGB), 0);
    check("mid_hs",   32'(bus.oHs), 1);
    check("mid_vs",   32'(bus.oVs), 1);
    check("mid_fs",   32'(bus.oFrameStart), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    Reset = 1'b0;

    wait_k(4); check("rs_fs_first", 32'(bus.oFrameStart), 1);
    wait_k(4); check("rs_d_fs", 32'(bus_d.oFrameStart), 1);
    wait_k(2 * 655 + 5); check("d_hs_h655", 32'(bus_d.oHs), 1);
    wait_k(2 * 656 + 4); check("d_hs_fall", 32'(bus_d.oHs), 0);
    wait_k(2 * 751 + 5); check("d_hs_h751", 32'(bus_d.oHs), 0);
    wait_k(2 * 752 + 4); check("d_hs_rise", 32'(bus_d.oHs), 1);
    wait_k(FRAME_K + 2); check("rs_fs_pre",  32'(bus.oFrameStart), 0);
    wait_k(FRAME_K + 4); check("rs_fs_next", 32'(bus.oFrameStart), 1);
    wait_k(FRAME_K + 5); check("rs_fs_count", 32'(fs_cnt), 2);
    wait_k(2 * (800 + 655) + 4); check("d_hs_l1_pre",  32'(bus_d.oHs), 1);
    wait_k(2 * (800 + 656) + 4); check("d_hs_l1_fall", 32'(bus_d.oHs), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
